mine_game_ctrl: RTL and testbench
=================================

MINE_GAME_CTRL -- requirements
Module: mine_game_ctrl

Interface
REQ-001 SHALL have parameter GRID_SIZE, default 3, board edge length; N = GRID_SIZE*GRID_SIZE cells.
REQ-002 SHALL have parameter STATE_SIZE, default 4, bits per cell state (0-8 = neighbour bomb count, 9 = bomb).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a new game.
REQ-006 SHALL have port bomb_map, input, N, bomb layout sampled on start.
REQ-007 SHALL have port btn_move, input, 1, one-cycle cursor-move request.
REQ-008 SHALL have port btn_dir, input, 2, move direction: 00 right, 01 up, 10 left, 11 down.
REQ-009 SHALL have port btn_reveal, input, 1, one-cycle reveal request.
REQ-010 SHALL have ports bombGrid, revealGrid and cursorGrid, each output, N, registered grids driven to the board.
REQ-011 SHALL have ports move (output, 1) and dir (output, 2), the board move strobe and direction.
REQ-012 SHALL have ports states (input, STATE_SIZE*N) and nextCursorGrid (input, N), the board's combinational results.
REQ-013 SHALL have outputs game_state (2: 00 IDLE, 01 PLAY, 10 WIN, 11 LOSE), busy (1) and reveal_count ($clog2(N+1)).

Function
REQ-014 Cell k SHALL map to bit k of every grid; grid layout is row-major from bottom-right (bit 0) to top-left (bit N-1).
REQ-015 The FSM states SHALL be IDLE, PLAY, MOVE, REVEAL, FLOOD, CHECK, WIN and LOSE; busy is 1 in MOVE, REVEAL, FLOOD and CHECK.
REQ-016 start in any state SHALL, on the next edge, load bombGrid=bomb_map, clear revealGrid to 0, set cursorGrid to bit 0, and enter PLAY.
REQ-017 In PLAY, btn_move SHALL enter MOVE; in MOVE, move=1 and dir=btn_dir latched for exactly one cycle, and nextCursorGrid is captured at the end of that cycle, returning to PLAY. The cursor therefore updates 2 edges after the pulse.
REQ-018 A captured nextCursorGrid of all zeros (move off edge) SHALL leave cursorGrid unchanged.
REQ-019 In PLAY, a simultaneous btn_reveal and btn_move SHALL take reveal; the move is dropped.
REQ-020 btn_move and btn_reveal SHALL be ignored outside PLAY.
REQ-021 In REVEAL, an already-revealed cursor cell SHALL return to PLAY with no change. Otherwise set its reveal bit, then: bomb -> LOSE; state != 0 -> CHECK; state == 0 -> FLOOD.
REQ-022 FLOOD SHALL perform one expansion pass per cycle. Each pass ORs into revealGrid every in-bounds 8-neighbour of each revealed non-bomb cell whose state is 0, never setting bomb cells. FLOOD exits to CHECK on the first pass that adds no bit; at most N passes.
REQ-023 reveal_count SHALL equal popcount(revealGrid) registered, valid in every state.
REQ-024 CHECK SHALL enter WIN if reveal_count == N - popcount(bombGrid), else PLAY.
REQ-025 WIN and LOSE SHALL hold all grids until start or reset; in LOSE, revealGrid is additionally ORed with bombGrid.
REQ-026 move SHALL be 0 in every state except MOVE.

Reset
REQ-027 resetn=0 at an edge SHALL force IDLE, all grids 0, move=0, dir=00 and reveal_count=0, from any state including mid-FLOOD; resetn takes priority over start.

Structure
REQ-028 FSM encodings, dir codes and game_state codes SHALL live in the shared package mine_pkg.
REQ-029 The combinational single-pass expansion SHALL be the sub-module mine_flood_step (inputs: grids and states; output: next revealGrid).

Verification
REQ-030 Reset: resetn=0 for 2 cycles -> game_state=00, all grids 0, move=0, reveal_count=0.
REQ-031 start with bomb_map=9'h003 -> cursorGrid=9'h001, PLAY; move dir=01 -> cursorGrid=9'h008 after 2 edges; move dir=00 from 9'h001 -> cursor stays 9'h001.
REQ-032 bomb_map=9'h003, reveal at cell 0 -> game_state=11 and revealGrid includes 9'h003.
REQ-033 bomb_map=9'h100, reveal at cell 0 -> FLOOD, final revealGrid=9'h0FF, reveal_count=8, game_state=10.
REQ-034 bomb_map=9'h100, move up then left (cursor 9'h010), reveal -> revealGrid=9'h010, reveal_count=1, PLAY.
REQ-035 resetn=0 during FLOOD -> IDLE with all grids 0 on the next edge; simultaneous btn_reveal and btn_move in PLAY -> reveal only, cursor unchanged.

Source files
------------

// File: rtl/mine_pkg.sv
// Shared encodings for the minesweeper game controller: FSM states,
// cursor move directions and externally visible game states.
package mine_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PLAY   = 3'd1;
    localparam logic [2:0] ST_MOVE   = 3'd2;
    localparam logic [2:0] ST_REVEAL = 3'd3;
    localparam logic [2:0] ST_FLOOD  = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_WIN    = 3'd6;
    localparam logic [2:0] ST_LOSE   = 3'd7;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_WIN  = 2'b10;
    localparam logic [1:0] GS_LOSE = 2'b11;

endpackage

// File: rtl/mine_flood_step.sv
// One combinational flood-fill pass: every revealed, bomb-free, zero-count
// cell exposes its in-bounds 8-neighbours (bombs are never exposed).
module mine_flood_step
    import mine_pkg::*;
#(
    parameter int GRID_SIZE  = 3,
    parameter int STATE_SIZE = 4,
    localparam int N = GRID_SIZE * GRID_SIZE
) (
    input  logic [N-1:0]            reveal_grid,
    input  logic [N-1:0]            bomb_grid,
    input  logic [STATE_SIZE*N-1:0] states,
    output logic [N-1:0]            next_grid
);

    localparam logic [N-1:0] ONE = N'(1);

    // Neighbour set of cell k; adjacency is symmetric, so it doubles as the source set.
    function automatic logic [N-1:0] adj_mask(input int k);
        logic [N-1:0] m;
        int r;
        int c;
        m = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                r = k / GRID_SIZE + dr;
                c = k % GRID_SIZE + dc;
                if (!(dr == 0 && dc == 0) && r >= 0 && r < GRID_SIZE && c >= 0 && c < GRID_SIZE)
                    m = m | (ONE << (r * GRID_SIZE + c));
            end
        end
        return m;
    endfunction

    logic [N-1:0] zero_src;

    for (genvar k = 0; k < N; k++) begin : g_src
        assign zero_src[k] = reveal_grid[k] & ~bomb_grid[k]
                           & (states[k*STATE_SIZE +: STATE_SIZE] == '0);
    end

    for (genvar j = 0; j < N; j++) begin : g_dst
        localparam logic [N-1:0] ADJ = adj_mask(j);
        assign next_grid[j] = reveal_grid[j] | (~bomb_grid[j] & (|(zero_src & ADJ)));
    end

endmodule

// File: rtl/mine_game_ctrl.sv
// Minesweeper game controller: owns the bomb/reveal/cursor grids, drives the
// board's move strobe and sequences reveal, flood-fill and win/lose checks.
module mine_game_ctrl
    import mine_pkg::*;
#(
    parameter int GRID_SIZE  = 3,
    parameter int STATE_SIZE = 4,
    localparam int N  = GRID_SIZE * GRID_SIZE,
    localparam int CW = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start,
    input  logic [N-1:0]            bomb_map,
    input  logic                    btn_move,
    input  logic [1:0]              btn_dir,
    input  logic                    btn_reveal,
    output logic [N-1:0]            bombGrid,
    output logic [N-1:0]            revealGrid,
    output logic [N-1:0]            cursorGrid,
    output logic                    move,
    output logic [1:0]              dir,
    input  logic [STATE_SIZE*N-1:0] states,
    input  logic [N-1:0]            nextCursorGrid,
    output logic [1:0]              game_state,
    output logic                    busy,
    output logic [CW-1:0]           reveal_count
);

    logic [2:0]    st, st_nx;
    logic [N-1:0]  bomb_nx, reveal_nx, cursor_nx, flood_grid, zero_cells;
    logic          move_nx;
    logic [1:0]    dir_nx;
    logic [CW-1:0] pass_cnt, pass_nx;
    logic          cur_bomb, cur_zero, cur_seen;

    mine_flood_step #(.GRID_SIZE(GRID_SIZE), .STATE_SIZE(STATE_SIZE)) u_flood (
        .reveal_grid (revealGrid),
        .bomb_grid   (bombGrid),
        .states      (states),
        .next_grid   (flood_grid)
    );

    for (genvar k = 0; k < N; k++) begin : g_zero
        assign zero_cells[k] = (states[k*STATE_SIZE +: STATE_SIZE] == '0);
    end

    // Cursor is one-hot, so masking selects the single cursor cell.
    assign cur_bomb = |(bombGrid & cursorGrid);
    assign cur_zero = |(zero_cells & cursorGrid);
    assign cur_seen = |(revealGrid & cursorGrid);

    always_comb begin
        st_nx     = st;
        bomb_nx   = bombGrid;
        reveal_nx = revealGrid;
        cursor_nx = cursorGrid;
        move_nx   = 1'b0;
        dir_nx    = dir;
        pass_nx   = pass_cnt;
        if (start) begin
            st_nx     = ST_PLAY;
            bomb_nx   = bomb_map;
            reveal_nx = '0;
            cursor_nx = N'(1);
        end else begin
            case (st)
                ST_PLAY: begin
                    if (btn_reveal) begin
                        st_nx = ST_REVEAL;
                    end else if (btn_move) begin
                        st_nx   = ST_MOVE;
                        move_nx = 1'b1;
                        dir_nx  = btn_dir;
                    end
                end
                ST_MOVE: begin
                    if (|nextCursorGrid) cursor_nx = nextCursorGrid;
                    st_nx = ST_PLAY;
                end
                ST_REVEAL: begin
                    if (cur_seen) begin
                        st_nx = ST_PLAY;
                    end else begin
                        reveal_nx = revealGrid | cursorGrid;
                        if (cur_bomb) begin
                            st_nx     = ST_LOSE;
                            reveal_nx = reveal_nx | bombGrid;
                        end else if (cur_zero) begin
                            st_nx   = ST_FLOOD;
                            pass_nx = '0;
                        end else begin
                            st_nx = ST_CHECK;
                        end
                    end
                end
                ST_FLOOD: begin
                    pass_nx = pass_cnt + CW'(1);
                    if (flood_grid == revealGrid) begin
                        st_nx = ST_CHECK;
                    end else begin
                        reveal_nx = flood_grid;
                        if (pass_cnt == CW'(N - 1)) st_nx = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (int'(reveal_count) == N - $countones(bombGrid)) st_nx = ST_WIN;
                    else st_nx = ST_PLAY;
                end
                ST_LOSE: reveal_nx = revealGrid | bombGrid;
                default: ;
            endcase
        end
    end

    // reveal_count is registered from the same next value as revealGrid so they never disagree.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            st           <= ST_IDLE;
            bombGrid     <= '0;
            revealGrid   <= '0;
            cursorGrid   <= '0;
            move         <= 1'b0;
            dir          <= DIR_RIGHT;
            pass_cnt     <= '0;
            reveal_count <= '0;
        end else begin
            st           <= st_nx;
            bombGrid     <= bomb_nx;
            revealGrid   <= reveal_nx;
            cursorGrid   <= cursor_nx;
            move         <= move_nx;
            dir          <= dir_nx;
            pass_cnt     <= pass_nx;
            reveal_count <= CW'($countones(reveal_nx));
        end
    end

    always_comb begin
        busy       = 1'b0;
        game_state = GS_PLAY;
        case (st)
            ST_IDLE: game_state = GS_IDLE;
            ST_WIN:  game_state = GS_WIN;
            ST_LOSE: game_state = GS_LOSE;
            ST_MOVE, ST_REVEAL, ST_FLOOD, ST_CHECK: busy = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mine_game_ctrl.sv
// Randomized bench for mine_game_ctrl against a cell-level game model with a
// queue-based flood fill; the board's combinational results are emulated here.
module tb_mine_game_ctrl;
    import mine_pkg::*;

    localparam int G = 3;
    localparam int N = 9;

    logic        clk = 1'b0;
    logic        resetn, start, btn_move, btn_reveal;
    logic [8:0]  bomb_map;
    logic [1:0]  btn_dir;
    logic [8:0]  bombGrid, revealGrid, cursorGrid, nextCursorGrid;
    logic        move, busy;
    logic [1:0]  dir, game_state;
    logic [35:0] states;
    logic [3:0]  reveal_count;

    int n_checks = 0;
    int n_errors = 0;

    mine_game_ctrl #(.GRID_SIZE(G), .STATE_SIZE(4)) dut (
        .clk(clk), .resetn(resetn), .start(start), .bomb_map(bomb_map),
        .btn_move(btn_move), .btn_dir(btn_dir), .btn_reveal(btn_reveal),
        .bombGrid(bombGrid), .revealGrid(revealGrid), .cursorGrid(cursorGrid),
        .move(move), .dir(dir), .states(states), .nextCursorGrid(nextCursorGrid),
        .game_state(game_state), .busy(busy), .reveal_count(reveal_count)
    );

    always #5 clk = ~clk;

    // ---------------- board emulation ----------------
    function automatic bit bit_at(input logic [8:0] v, input int k);
        return ((v >> k) & 9'd1) != 9'd0;
    endfunction

    function automatic logic [35:0] board_states(input logic [8:0] bg);
        logic [35:0] s;
        int n;
        s = '0;
        for (int k = 0; k < N; k++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    if (!(dr == 0 && dc == 0) && k/G+dr >= 0 && k/G+dr < G && k%G+dc >= 0 && k%G+dc < G)
                        if (bit_at(bg, (k/G+dr)*G + k%G+dc)) n++;
            if (bit_at(bg, k)) n = 9;
            s = s | (36'(n) << (4*k));
        end
        return s;
    endfunction

    function automatic logic [8:0] board_next(input logic [8:0] cg, input logic [1:0] d);
        int r, c;
        for (int k = 0; k < N; k++) begin
            if (bit_at(cg, k)) begin
                r = k / G;
                c = k % G;
                case (d)
                    DIR_RIGHT: c = c - 1;
                    DIR_UP:    r = r + 1;
                    DIR_LEFT:  c = c + 1;
                    default:   r = r - 1;
                endcase
                if (r >= 0 && r < G && c >= 0 && c < G) return 9'd1 << (r*G + c);
                return 9'd0;
            end
        end
        return 9'd0;
    endfunction

    always_comb begin
        states         = board_states(bombGrid);
        nextCursorGrid = board_next(cursorGrid, dir);
    end

    // ---------------- reference model ----------------
    bit         mb [G][G];
    bit         mr [G][G];
    int         cr, cc;
    logic [1:0] m_gs;

    function automatic int nb_count(input int r, input int c);
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < G && c+dc >= 0 && c+dc < G)
                    if (mb[r+dr][c+dc]) n++;
        return n;
    endfunction

    function automatic logic [8:0] m_bits(input bit use_bomb);
        logic [8:0] v = '0;
        for (int r = 0; r < G; r++)
            for (int c = 0; c < G; c++)
                if (use_bomb ? mb[r][c] : mr[r][c]) v = v | (9'd1 << (r*G + c));
        return v;
    endfunction

    function automatic logic [8:0] m_cursor();
        if (cr < 0) return 9'd0;
        return 9'd1 << (cr*G + cc);
    endfunction

    task automatic m_reset();
        for (int r = 0; r < G; r++)
            for (int c = 0; c < G; c++) begin
                mb[r][c] = 1'b0;
                mr[r][c] = 1'b0;
            end
        cr = -1;
        cc = -1;
        m_gs = GS_IDLE;
    endtask

    task automatic m_reveal();
        int q[$];
        int k, r, c, seen, bombs;
        if (mr[cr][cc]) return;
        mr[cr][cc] = 1'b1;
        if (mb[cr][cc]) begin
            m_gs = GS_LOSE;
            for (int i = 0; i < G; i++)
                for (int j = 0; j < G; j++)
                    if (mb[i][j]) mr[i][j] = 1'b1;
            return;
        end
        if (nb_count(cr, cc) == 0) q.push_back(cr*G + cc);
        while (q.size() > 0) begin
            k = q.pop_front();
            r = k / G;
            c = k % G;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    if (r+dr >= 0 && r+dr < G && c+dc >= 0 && c+dc < G)
                        if (!mb[r+dr][c+dc] && !mr[r+dr][c+dc]) begin
                            mr[r+dr][c+dc] = 1'b1;
                            if (nb_count(r+dr, c+dc) == 0) q.push_back((r+dr)*G + c+dc);
                        end
        end
        seen = $countones(m_bits(1'b0));
        bombs = $countones(m_bits(1'b1));
        if (seen == N - bombs) m_gs = GS_WIN;
    endtask

    task automatic m_apply(input bit st, input logic [8:0] map, input bit mv,
                           input logic [1:0] d, input bit rv);
        if (st) begin
            for (int r = 0; r < G; r++)
                for (int c = 0; c < G; c++) begin
                    mb[r][c] = bit_at(map, r*G + c);
                    mr[r][c] = 1'b0;
                end
            cr = 0;
            cc = 0;
            m_gs = GS_PLAY;
        end else if (m_gs == GS_PLAY) begin
            if (rv) m_reveal();
            else if (mv) begin
                case (d)
                    DIR_RIGHT: if (cc > 0)     cc--;
                    DIR_UP:    if (cr < G - 1) cr++;
                    DIR_LEFT:  if (cc < G - 1) cc++;
                    default:   if (cr > 0)     cr--;
                endcase
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        chk("game_state", 32'(game_state), 32'(m_gs));
        chk("bombGrid", 32'(bombGrid), 32'(m_bits(1'b1)));
        chk("revealGrid", 32'(revealGrid), 32'(m_bits(1'b0)));
        chk("cursorGrid", 32'(cursorGrid), 32'(m_cursor()));
        chk("reveal_count", 32'(reveal_count), 32'($countones(m_bits(1'b0))));
        chk("move_low", 32'(move), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        start = 1'b0; btn_move = 1'b0; btn_reveal = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        m_reset();
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        compare_all();
    endtask

    task automatic op(input bit st, input logic [8:0] map, input bit mv,
                      input logic [1:0] d, input bit rv);
        logic [8:0] old_cur;
        bit exp_move;
        int cnt;
        old_cur  = m_cursor();
        exp_move = !st && m_gs == GS_PLAY && mv && !rv;
        @(negedge clk);
        start = st; bomb_map = map; btn_move = mv; btn_dir = d; btn_reveal = rv;
        @(negedge clk);
        start = 1'b0; btn_move = 1'b0; btn_reveal = 1'b0;
        if (exp_move) begin
            chk("move_strobe", 32'(move), 32'd1);
            chk("move_dir", 32'(dir), 32'(d));
            chk("cursor_hold", 32'(cursorGrid), 32'(old_cur));
        end else begin
            chk("move_idle", 32'(move), 32'd0);
        end
        m_apply(st, map, mv, d, rv);
        cnt = 0;
        while (busy && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        chk("settle", 32'(busy), 32'd0);
        compare_all();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bit mv, rv;
        int r;
        logic [8:0] map;
        resetn = 1'b0; start = 1'b0; bomb_map = '0;
        btn_move = 1'b0; btn_dir = 2'b00; btn_reveal = 1'b0;
        m_reset();
        do_reset();
        chk("reset_gs", 32'(game_state), 32'(GS_IDLE));

        op(1'b1, 9'h003, 1'b0, 2'b00, 1'b0);
        chk("start_cursor", 32'(cursorGrid), 32'h001);
        op(1'b0, 9'h0, 1'b1, DIR_UP, 1'b0);
        chk("cursor_up", 32'(cursorGrid), 32'h008);
        op(1'b1, 9'h003, 1'b0, 2'b00, 1'b0);
        op(1'b0, 9'h0, 1'b1, DIR_RIGHT, 1'b0);
        chk("cursor_edge", 32'(cursorGrid), 32'h001);
        op(1'b0, 9'h0, 1'b0, 2'b00, 1'b1);
        chk("lose_gs", 32'(game_state), 32'(GS_LOSE));
        chk("lose_bombs", 32'(revealGrid & 9'h003), 32'h003);

        op(1'b1, 9'h100, 1'b0, 2'b00, 1'b0);
        op(1'b0, 9'h0, 1'b0, 2'b00, 1'b1);
        chk("flood_grid", 32'(revealGrid), 32'h0FF);
        chk("flood_count", 32'(reveal_count), 32'd8);
        chk("win_gs", 32'(game_state), 32'(GS_WIN));

        op(1'b1, 9'h100, 1'b0, 2'b00, 1'b0);
        op(1'b0, 9'h0, 1'b1, DIR_UP, 1'b0);
        op(1'b0, 9'h0, 1'b1, DIR_LEFT, 1'b0);
        chk("cursor_center", 32'(cursorGrid), 32'h010);
        op(1'b0, 9'h0, 1'b0, 2'b00, 1'b1);
        chk("center_grid", 32'(revealGrid), 32'h010);
        chk("center_count", 32'(reveal_count), 32'd1);
        chk("center_gs", 32'(game_state), 32'(GS_PLAY));

        op(1'b1, 9'h100, 1'b0, 2'b00, 1'b0);
        op(1'b0, 9'h0, 1'b1, DIR_UP, 1'b1);
        chk("both_cursor", 32'(cursorGrid), 32'h001);
        chk("both_grid", 32'(revealGrid), 32'h0FF);

        // reset lands while the flood is still expanding; start on the same edge loses
        op(1'b1, 9'h100, 1'b0, 2'b00, 1'b0);
        @(negedge clk) btn_reveal = 1'b1;
        @(negedge clk) btn_reveal = 1'b0;
        @(negedge clk);
        chk("flood_busy", 32'(busy), 32'd1);
        chk("flood_partial", 32'(revealGrid), 32'h001);
        resetn = 1'b0; start = 1'b1; bomb_map = 9'h1FF;
        @(negedge clk);
        resetn = 1'b1; start = 1'b0;
        m_reset();
        chk("midflood_gs", 32'(game_state), 32'(GS_IDLE));
        compare_all();

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            map = 9'($urandom) & 9'($urandom);
            if ($urandom_range(0, 1) == 1) map = map & 9'($urandom);
            mv = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            if (r < 3) begin
                do_reset();
            end else if (r < 15) begin
                op(1'b1, map, mv, 2'($urandom), rv);
            end else begin
                if (!mv && !rv) mv = 1'b1;
                op(1'b0, 9'h0, mv, 2'($urandom), rv);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
